// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings (HTRANS, HBURST, HSIZE) and the arbiter transfer code.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef enum logic [1:0] {
        XFER_SINGLE     = 2'b00,
        XFER_INCR4      = 2'b01,
        XFER_INCR8      = 2'b10,
        XFER_SINGLE_ALT = 2'b11
    } xfer_e;

    function automatic hburst_e burst_of(input logic [1:0] code);
        case (code)
            XFER_INCR4: burst_of = HBURST_INCR4;
            XFER_INCR8: burst_of = HBURST_INCR8;
            default:    burst_of = HBURST_SINGLE;
        endcase
    endfunction

    // Index of the final beat, so a 3-bit counter covers INCR8.
    function automatic logic [2:0] last_beat_of(input logic [1:0] code);
        case (code)
            XFER_INCR4: last_beat_of = 3'd3;
            XFER_INCR8: last_beat_of = 3'd7;
            default:    last_beat_of = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_lite_master.sv
// AHB-Lite master: single/INCR4/INCR8 word transfers, NONSEQ one cycle after request.
// Stalls on HREADY=0 with address/control held; ERROR cancels remaining beats.
module ahb_lite_master
    import ahb_pkg::*;
#(
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        write,
    input  logic [31:0] wdata,
    input  logic [2:0]  transfer,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic [1:0]  HTRANS,
    output logic [31:0] HADDR,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [1:0]  HTRANS_BUS,
    output logic [3:0]  HPROT,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    input  logic        HRESP
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_BURST = 3'd2,
        S_LAST  = 3'd3,
        S_ERR   = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    hburst_e     hburst_q, hburst_d;
    logic [2:0]  last_q, last_d;
    logic [2:0]  beat_q, beat_d;
    htrans_e     htrans_c;
    logic        data_phase_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            haddr_q  <= 32'd0;
            hwrite_q <= 1'b0;
            hburst_q <= HBURST_SINGLE;
            last_q   <= 3'd0;
            beat_q   <= 3'd0;
        end else begin
            state_q  <= state_d;
            haddr_q  <= haddr_d;
            hwrite_q <= hwrite_d;
            hburst_q <= hburst_d;
            last_q   <= last_d;
            beat_q   <= beat_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        haddr_d      = haddr_q;
        hwrite_d     = hwrite_q;
        hburst_d     = hburst_q;
        last_d       = last_q;
        beat_d       = beat_q;
        htrans_c     = HTRANS_IDLE;
        data_phase_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (transfer[2]) begin
                    haddr_d  = addr;
                    hwrite_d = write;
                    hburst_d = burst_of(transfer[1:0]);
                    last_d   = last_beat_of(transfer[1:0]);
                    beat_d   = 3'd0;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                htrans_c = HTRANS_NONSEQ;
                if (HREADY) begin
                    beat_d = 3'd1;
                    if (last_q == 3'd0) begin
                        state_d = S_LAST;
                    end else begin
                        haddr_d = haddr_q + 32'd4;
                        state_d = S_BURST;
                    end
                end
            end
            S_BURST: begin
                htrans_c     = HTRANS_SEQ;
                data_phase_c = 1'b1;
                if (HREADY) begin
                    if (HRESP) begin
                        beat_d  = 3'd0;
                        state_d = S_IDLE;
                    end else if (beat_q == last_q) begin
                        state_d = S_LAST;
                    end else begin
                        beat_d  = beat_q + 3'd1;
                        haddr_d = haddr_q + 32'd4;
                    end
                end else if (HRESP) begin
                    // First cycle of a two-cycle ERROR: withdraw the pending SEQ.
                    state_d = S_ERR;
                end
            end
            S_LAST: begin
                data_phase_c = 1'b1;
                if (HREADY) begin
                    beat_d  = 3'd0;
                    state_d = S_IDLE;
                end else if (HRESP) begin
                    state_d = S_ERR;
                end
            end
            S_ERR: begin
                data_phase_c = 1'b1;
                if (HREADY) begin
                    beat_d  = 3'd0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ready      = data_phase_c & HREADY;
    assign err        = ready & HRESP;
    assign rdata      = HRDATA;
    assign HTRANS_BUS = htrans_c;
    assign HTRANS     = htrans_c;
    assign HADDR      = haddr_q;
    assign HWRITE     = hwrite_q;
    assign HBURST     = hburst_q;
    assign HSIZE      = HSIZE_WORD;
    assign HPROT      = HPROT_VAL;
    assign HWDATA     = (data_phase_c && hwrite_q) ? wdata : 32'd0;

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: transaction-level model checked every cycle, plus directed literal checks.
module tb_ahb_lite_master;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata, rdata, HADDR, HWDATA, HRDATA;
    logic        write, ready, err, HWRITE, HREADY, HRESP;
    logic [2:0]  transfer, HSIZE, HBURST;
    logic [1:0]  HTRANS, HTRANS_BUS;
    logic [3:0]  HPROT;

    always #5 clk = ~clk;

    ahb_lite_master dut (
        .clk(clk), .rst(rst), .addr(addr), .write(write), .wdata(wdata),
        .transfer(transfer), .rdata(rdata), .ready(ready), .err(err),
        .HTRANS(HTRANS), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HTRANS_BUS(HTRANS_BUS), .HPROT(HPROT),
        .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Request-level model: beat indices of accepted addresses and the outstanding data phase.
    bit          m_busy, m_write, m_dv, m_errcyc;
    int          m_len, m_aidx, m_didx;
    logic [31:0] m_addr;
    logic [2:0]  m_burst;
    logic [31:0] wsalt = 32'hA5A5_0000;

    function automatic int len_of(input logic [1:0] c);
        return (c == 2'b01) ? 4 : (c == 2'b10) ? 8 : 1;
    endfunction

    function automatic logic [2:0] burst_code(input logic [1:0] c);
        return (c == 2'b01) ? 3'b011 : (c == 2'b10) ? 3'b101 : 3'b000;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_dv = 0; m_errcyc = 0; m_aidx = 0; m_didx = 0; m_len = 0;
    endtask

    task automatic model_compare();
        bit          aph, dp;
        logic [31:0] et;
        aph = m_busy && !m_errcyc && (m_aidx < m_len);
        dp  = m_busy && m_dv;
        et  = aph ? ((m_aidx == 0) ? 32'd2 : 32'd3) : 32'd0;
        chk("HTRANS_BUS", HTRANS_BUS, et);
        chk("HTRANS", HTRANS, et);
        if (aph) begin
            chk("HADDR", HADDR, m_addr + 32'(4 * m_aidx));
            chk("HWRITE", HWRITE, m_write);
            chk("HBURST", HBURST, m_burst);
        end
        chk("HSIZE", HSIZE, 32'd2);
        chk("HPROT", HPROT, 32'd3);
        chk("ready", ready, dp && HREADY);
        chk("err", err, dp && HREADY && HRESP);
        chk("HWDATA", HWDATA, (dp && m_write) ? wdata : 32'd0);
        chk("rdata", rdata, HRDATA);
    endtask

    task automatic model_update();
        bit aph;
        if (!m_busy) begin
            if (transfer[2]) begin
                m_busy = 1; m_addr = addr; m_write = write;
                m_len = len_of(transfer[1:0]); m_burst = burst_code(transfer[1:0]);
                m_aidx = 0; m_dv = 0; m_errcyc = 0;
            end
        end else begin
            aph = !m_errcyc && (m_aidx < m_len);
            if (HREADY) begin
                if (m_dv && HRESP) m_busy = 0;
                if (m_busy) begin
                    if (aph) begin
                        m_didx = m_aidx; m_aidx++; m_dv = 1;
                    end else begin
                        m_dv = 0; m_busy = 0;
                    end
                end else begin
                    m_dv = 0;
                end
            end else if (m_dv && HRESP) begin
                m_errcyc = 1;
            end
        end
    endtask

    task automatic step(input logic [2:0] xf, input logic [31:0] a, input logic w,
                        input logic hr, input logic hresp);
        @(posedge clk);
        #1;
        transfer = xf; addr = a; write = w; HREADY = hr; HRESP = hresp;
        HRDATA = $urandom;
        wdata  = wsalt + 32'(m_didx) * 32'h0101;
        @(negedge clk);
        model_compare();
        model_update();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_HTRANS_BUS"}, HTRANS_BUS, 32'd0);
        chk({tag, "_HADDR"}, HADDR, 32'd0);
        chk({tag, "_HWRITE"}, HWRITE, 32'd0);
        chk({tag, "_HBURST"}, HBURST, 32'd0);
        chk({tag, "_HSIZE"}, HSIZE, 32'd2);
        chk({tag, "_HWDATA"}, HWDATA, 32'd0);
        chk({tag, "_ready"}, ready, 32'd0);
        chk({tag, "_err"}, err, 32'd0);
    endtask

    initial begin
        int  nrdy, nerr;
        bit  err_pend;
        logic       hr, hresp;
        logic [2:0] xf;

        rst = 1'b0; transfer = 3'b000; addr = 32'd0; write = 1'b0; wdata = 32'd0;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'd0;
        model_reset();
        #23;
        chk_reset_values("init");
        @(negedge clk);
        rst = 1'b1;

        // Single read at 0x100, zero wait states
        step(3'b100, 32'h100, 1'b0, 1'b1, 1'b0);
        chk("t1_c0_idle", HTRANS_BUS, 32'd0);
        step(3'b000, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("t1_c1_nonseq", HTRANS_BUS, 32'd2);
        chk("t1_c1_haddr", HADDR, 32'h100);
        step(3'b000, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("t1_c2_ready", ready, 32'd1);
        chk("t1_c2_rdata", rdata, HRDATA);
        step(3'b000, 32'h0, 1'b0, 1'b1, 1'b0);
        chk("t1_c3_idle", HTRANS_BUS, 32'd0);
        chk("t1_c3_ready", ready, 32'd0);

        // INCR8 read at 0x200, zero wait states
        step(3'b110, 32'h200, 1'b0, 1'b1, 1'b0);
        nrdy = 0;
        for (int k = 1; k <= 10; k++) begin
            step(3'b000, 32'h0, 1'b0, 1'b1, 1'b0);
            if (k <= 8) begin
                chk("t2_htrans", HTRANS_BUS, (k == 1) ? 32'd2 : 32'd3);
                chk("t2_haddr", HADDR, 32'h200 + 32'(4 * (k - 1)));
                chk("t2_hburst", HBURST, 32'd5);
            end else begin
                chk("t2_tail_idle", HTRANS_BUS, 32'd0);
            end
            if (k >= 2 && k <= 9) nrdy += int'(ready);
            else chk("t2_no_ready", ready, 32'd0);
        end
        chk("t2_ready_count", nrdy, 32'd8);

        // INCR4 write at 0x40, two wait states on beat 2
        wsalt = 32'hA5A5_0000;
        step(3'b101, 32'h40, 1'b1, 1'b1, 1'b0);
        nrdy = 0;
        for (int k = 1; k <= 9; k++) begin
            step(3'b000, 32'h0, 1'b0, (k == 3 || k == 4) ? 1'b0 : 1'b1, 1'b0);
            nrdy += int'(ready);
            if (k == 4) begin
                chk("t3_hold_haddr", HADDR, 32'h48);
                chk("t3_hold_htrans", HTRANS_BUS, 32'd3);
                chk("t3_hold_hwrite", HWRITE, 32'd1);
                chk("t3_hold_hburst", HBURST, 32'd3);
                chk("t3_hold_hwdata", HWDATA, 32'hA5A5_0101);
                chk("t3_hold_ready", ready, 32'd0);
            end
        end
        chk("t3_ready_count", nrdy, 32'd4);

        // ERROR on beat 3 of an INCR8 read
        step(3'b110, 32'h300, 1'b0, 1'b1, 1'b0);
        nrdy = 0; nerr = 0;
        for (int k = 1; k <= 9; k++) begin
            step(3'b000, 32'h0, 1'b0, (k == 4) ? 1'b0 : 1'b1, (k == 4 || k == 5) ? 1'b1 : 1'b0);
            nrdy += int'(ready);
            nerr += int'(err);
            if (k == 4) begin
                chk("t4_c4_haddr", HADDR, 32'h30C);
                chk("t4_c4_ready", ready, 32'd0);
            end
            if (k >= 5) chk("t4_cancel_idle", HTRANS_BUS, 32'd0);
            if (k == 5) begin
                chk("t4_c5_ready", ready, 32'd1);
                chk("t4_c5_err", err, 32'd1);
            end
        end
        chk("t4_ready_count", nrdy, 32'd3);
        chk("t4_err_count", nerr, 32'd1);

        // Reset in the middle of an INCR8 burst, then a single read
        step(3'b110, 32'h400, 1'b1, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) step(3'b000, 32'h0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk_reset_values("midrst");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step(3'b100, 32'h500, 1'b0, 1'b1, 1'b0);
        nrdy = 0;
        for (int k = 1; k <= 4; k++) begin
            step(3'b000, 32'h0, 1'b0, 1'b1, 1'b0);
            nrdy += int'(ready);
            if (k == 1) begin
                chk("t5_nonseq", HTRANS_BUS, 32'd2);
                chk("t5_haddr", HADDR, 32'h500);
            end
        end
        chk("t5_ready_count", nrdy, 32'd1);

        // Randomized traffic with wait states, errors and requests presented while busy
        err_pend = 0;
        wsalt = $urandom;
        for (int i = 0; i < 3000; i++) begin
            if (err_pend) begin
                hr = 1'b1; hresp = 1'b1; err_pend = 0;
            end else if (m_busy && m_dv && $urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    hr = 1'b0; hresp = 1'b1; err_pend = 1;
                end else begin
                    hr = 1'b1; hresp = 1'b1;
                end
            end else begin
                hr = ($urandom_range(0, 3) != 0); hresp = 1'b0;
            end
            if (!m_busy) xf = {($urandom_range(0, 2) == 0), 2'($urandom)};
            else xf = 3'($urandom);
            step(xf, $urandom & 32'hFFFF_FFE0, 1'($urandom), hr, hresp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_lite_master.md
AHB_LITE_MASTER -- requirements
Module: ahb_lite_master

Interface
REQ-001 SHALL have parameter HPROT_VAL, default 4'b0011, constant value driven on HPROT.
REQ-002 SHALL have port clk  input  1  single clock; all flops rising-edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port addr  input  32  request start address, word-aligned.
REQ-005 SHALL have port write  input  1  1 = write request, 0 = read request.
REQ-006 SHALL have port wdata  input  32  write data for the beat currently in data phase.
REQ-007 SHALL have port transfer  input  3  bit2 = request valid; bits1:0 = 00 single, 01 INCR4, 10 INCR8, 11 single.
REQ-008 SHALL have port rdata  output  32  read data, equal to HRDATA.
REQ-009 SHALL have port ready  output  1  one-cycle pulse per completed beat.
REQ-010 SHALL have port err  output  1  qualifies ready; beat ended with ERROR response.
REQ-011 SHALL have port HTRANS  output  2  copy of HTRANS_BUS for arbiter phase tracking.
REQ-012 SHALL have bus ports HADDR out 32, HWRITE out 1, HSIZE out 3, HBURST out 3, HTRANS_BUS out 2, HPROT out 4, HWDATA out 32, HREADY in 1, HRDATA in 32, HRESP in 1.

Function
REQ-013 SHALL implement FSM IDLE, ADDR (NONSEQ issued), BURST (SEQ beats), LAST (final data phase only), ERR (error cancel cycle).
REQ-014 SHALL, in IDLE with transfer[2]=1, register addr/write/burst code and drive NONSEQ on the next cycle (request-to-bus latency 1).
REQ-015 SHALL drive HSIZE=3'b010 and HBURST = 000 single, 011 INCR4, 101 INCR8 for every beat of a request.
REQ-016 SHALL increment HADDR by 4 per accepted beat; no wrap; bursts never cross a 1 KB boundary (arbiter guarantee).
REQ-017 SHALL keep a 3-bit beat counter; address phase of beat n overlaps data phase of beat n-1.
REQ-018 SHALL advance address/data phases only on cycles with HREADY=1; HADDR, HTRANS_BUS, HWRITE, HBURST SHALL hold stable while HREADY=0.
REQ-019 SHALL assert ready combinationally when a data phase is active and HREADY=1 with HRESP=0.
REQ-020 SHALL drive HWDATA = wdata during write data phases, 0 otherwise; the arbiter updates wdata after each ready.
REQ-021 SHALL drive HTRANS_BUS=IDLE after the last address phase and return to IDLE after the last ready.
REQ-022 SHALL ignore transfer in the cycle of the final ready; a new request is accepted no earlier than the following cycle.
REQ-023 SHALL, on HRESP=1 with HREADY=0, drive HTRANS_BUS=IDLE next cycle (enter ERR); on HRESP=1 with HREADY=1, pulse ready=1 and err=1, abandon remaining beats, go IDLE.
REQ-024 SHALL hold err=0 whenever ready=0.

Reset
REQ-025 SHALL, on rst low, immediately force FSM=IDLE, beat counter=0, HTRANS_BUS=IDLE, HADDR=0, HWRITE=0, HBURST=0, HSIZE=3'b010, HWDATA=0, ready=0, err=0, including mid-burst.
REQ-026 SHALL accept a new request only after rst is deasserted and a full clock edge has occurred.

Structure
REQ-027 SHALL take HTRANS (IDLE/BUSY/NONSEQ/SEQ), HBURST, HSIZE and transfer-code encodings from shared package ahb_pkg.
REQ-028 SHALL be a single module; no sub-module is natural.

Verification
REQ-029 SHALL cover: single read at 0x100, HREADY always 1 -> NONSEQ 0x100 in cycle 1, ready with rdata=HRDATA in cycle 2, IDLE in cycle 3.
REQ-030 SHALL cover: INCR8 read at 0x200 with zero wait states -> HADDR 0x200..0x21C, NONSEQ then 7 SEQ, exactly 8 ready pulses in cycles 2-9.
REQ-031 SHALL cover: INCR4 write at 0x40, HREADY low 2 cycles during beat 2 -> address/control held, HWDATA equal to the beat-2 wdata, 4 ready pulses.
REQ-032 SHALL cover: ERROR on beat 3 of an INCR8 read -> HTRANS_BUS IDLE in the following cycle, single ready+err pulse, no further beats.
REQ-033 SHALL cover: rst low in the middle of an INCR8 burst -> all outputs at reset values in the same cycle; a new single read after release completes normally.
